// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the divider request sequencer.
package div_sequencer_pkg;

    localparam int unsigned OpW = 32;

    localparam logic [1:0] StateIdleEnc  = 2'd0;
    localparam logic [1:0] StateIssueEnc = 2'd1;
    localparam logic [1:0] StateArmEnc   = 2'd2;
    localparam logic [1:0] StateWaitEnc  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = StateIdleEnc,
        StIssue = StateIssueEnc,
        StArm   = StateArmEnc,
        StWait  = StateWaitEnc
    } seq_state_e;

    // A zero on either side has a trivial answer and never reaches the divider.
    function automatic logic is_bypass(input logic [OpW-1:0] dividend,
                                       input logic [OpW-1:0] divisor);
        return (dividend == '0) || (divisor == '0);
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// First-word-fall-through request FIFO; head entry is visible on rdata while not empty.
module div_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en, pop_en;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Queues signed divide requests, feeds them one at a time to an external divider core,
// short-circuits zero operands, and returns results in request order.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OpW-1:0]   req_dividend,
    input  logic [OpW-1:0]   req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_calc,
    output logic [OpW-1:0]   div_dividend,
    output logic [OpW-1:0]   div_divisor,
    input  logic             div_done,
    input  logic [OpW-1:0]   div_quotient,
    input  logic [OpW-1:0]   div_remainder,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OpW-1:0]   res_quotient,
    output logic [OpW-1:0]   res_remainder,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_dbz
);
    localparam int unsigned EntryW = 2 * OpW + TAG_W;

    logic [EntryW-1:0] fifo_wdata, fifo_rdata;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [OpW-1:0]    head_dividend, head_divisor;
    logic [TAG_W-1:0]  head_tag;

    seq_state_e        state_q, state_d;
    logic [OpW-1:0]    op_dividend_q, op_dividend_d;
    logic [OpW-1:0]    op_divisor_q, op_divisor_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic              res_valid_q, res_valid_d;
    logic [OpW-1:0]    res_quotient_q, res_quotient_d;
    logic [OpW-1:0]    res_remainder_q, res_remainder_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic              res_dbz_q, res_dbz_d;

    assign fifo_wdata = {req_dividend, req_divisor, req_tag};
    assign {head_dividend, head_divisor, head_tag} = fifo_rdata;
    assign req_ready  = !fifo_full;

    div_req_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EntryW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (req_valid),
        .wdata(fifo_wdata),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d         = state_q;
        fifo_pop        = 1'b0;
        op_dividend_d   = op_dividend_q;
        op_divisor_d    = op_divisor_q;
        op_tag_d        = op_tag_q;
        res_valid_d     = res_valid_q && !res_ready;
        res_quotient_d  = res_quotient_q;
        res_remainder_d = res_remainder_q;
        res_tag_d       = res_tag_q;
        res_dbz_d       = res_dbz_q;
        case (state_q)
            StIdle: begin
                // The result slot must be free (or draining now) so nothing is dropped.
                if (!fifo_empty && (!res_valid_q || res_ready) && div_done) begin
                    fifo_pop = 1'b1;
                    if (is_bypass(head_dividend, head_divisor)) begin
                        res_valid_d     = 1'b1;
                        res_quotient_d  = '0;
                        res_remainder_d = '0;
                        res_tag_d       = head_tag;
                        res_dbz_d       = (head_divisor == '0);
                    end else begin
                        op_dividend_d = head_dividend;
                        op_divisor_d  = head_divisor;
                        op_tag_d      = head_tag;
                        state_d       = StIssue;
                    end
                end
            end
            StIssue: state_d = StArm;
            // The core lowers done one edge late, so done seen here is stale.
            StArm:   state_d = StWait;
            StWait: begin
                if (div_done) begin
                    res_valid_d     = 1'b1;
                    res_quotient_d  = div_quotient;
                    res_remainder_d = div_remainder;
                    res_tag_d       = op_tag_q;
                    res_dbz_d       = 1'b0;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            op_dividend_q   <= '0;
            op_divisor_q    <= '0;
            op_tag_q        <= '0;
            res_valid_q     <= 1'b0;
            res_quotient_q  <= '0;
            res_remainder_q <= '0;
            res_tag_q       <= '0;
            res_dbz_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_dividend_q   <= op_dividend_d;
            op_divisor_q    <= op_divisor_d;
            op_tag_q        <= op_tag_d;
            res_valid_q     <= res_valid_d;
            res_quotient_q  <= res_quotient_d;
            res_remainder_q <= res_remainder_d;
            res_tag_q       <= res_tag_d;
            res_dbz_q       <= res_dbz_d;
        end
    end

    assign div_calc      = (state_q == StIssue);
    assign div_dividend  = op_dividend_q;
    assign div_divisor   = op_divisor_q;
    assign res_valid     = res_valid_q;
    assign res_quotient  = res_quotient_q;
    assign res_remainder = res_remainder_q;
    assign res_tag       = res_tag_q;
    assign res_dbz       = res_dbz_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth (power of two, >=2).
REQ-002 Parameter TAG_W, default 4, width of the request tag.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  request offered; req_ready  output  1  request accepted when both high.
REQ-006 req_dividend, req_divisor  input  32 each  signed two's-complement operands; req_tag  input  TAG_W  caller tag.
REQ-007 div_calc  output  1  one-cycle start pulse to the signed 32-bit divider core.
REQ-008 div_dividend, div_divisor  output  32 each  operands to divider, held stable from the div_calc cycle until capture.
REQ-009 div_done  input  1  divider idle/finished level, high when idle.
REQ-010 div_quotient, div_remainder  input  32 each  divider results, valid while div_done high after a run.
REQ-011 res_valid  output  1; res_ready  input  1  result handshake, transfer when both high.
REQ-012 res_quotient, res_remainder  output  32 each; res_tag  output  TAG_W; res_dbz  output  1  divisor-was-zero flag.

Function
REQ-013 Request FIFO of DEPTH entries {dividend, divisor, tag}; req_ready = FIFO not full; push on req_valid&&req_ready.
REQ-014 Full FIFO: req_ready low, no entry overwritten; pop and push in the same cycle permitted when not full, count unchanged.
REQ-015 Pointers wrap modulo DEPTH; occupancy counter range 0..DEPTH.
REQ-016 FSM states IDLE, ISSUE, ARM, WAIT.
REQ-017 IDLE: pop head only when FIFO non-empty, res_valid low (or being consumed this cycle), and div_done high.
REQ-018 IDLE pop with dividend==0 or divisor==0: bypass divider; next edge load res_quotient=0, res_remainder=0, res_dbz=(divisor==0), res_tag, res_valid=1; stay IDLE.
REQ-019 IDLE pop with both operands nonzero: latch operands/tag into div_dividend/div_divisor/tag register, go ISSUE.
REQ-020 ISSUE: div_calc high for exactly this one cycle; next state ARM.
REQ-021 ARM: div_done ignored for one cycle (core drops done one edge after calc); next state WAIT.
REQ-022 WAIT: on div_done high, capture div_quotient/div_remainder into result register, res_dbz=0, res_valid=1, go IDLE.
REQ-023 Result register holds values and res_valid until res_valid&&res_ready; at most one divider run in flight.
REQ-024 Latency: request into empty FIFO with idle sequencer appears at head one edge after push; bypass result res_valid 2 edges after push; divider result res_valid one edge after first WAIT cycle with div_done high.
REQ-025 Responses leave in request order; tags returned unmodified.
REQ-026 div_calc never asserted outside ISSUE; operands never change between ISSUE and capture.

Reset
REQ-027 rst_n low asynchronously: FIFO emptied, FSM IDLE, req_ready=1, res_valid=0, res_quotient/res_remainder/res_tag/res_dbz=0, div_calc=0, div_dividend/div_divisor=0.
REQ-028 Reset mid-run abandons the in-flight operation; no result produced for it; first post-reset issue waits for div_done high (REQ-017).

Structure
REQ-029 Shared package holds FSM state encoding localparams and the 32-bit operand width constant.
REQ-030 Request FIFO is one sub-module, div_req_fifo (parameterised DEPTH and entry width); divider core instantiated outside this block.

Verification
REQ-031 Push 100/7 tag 3, res_ready=1, behavioural divider -> one div_calc pulse, result quotient 14, remainder 2, tag 3, dbz 0.
REQ-032 Push -100/7 then 0/5 then 9/0 -> results in order: (-14,-2), (0,0,dbz 0), (0,0,dbz 1); exactly one div_calc pulse total.
REQ-033 res_ready low, push 5 requests DEPTH=4 -> req_ready low once FIFO full, first result held stable, no further div_calc until res_ready high; all 5 drain in order.
REQ-034 Simultaneous push and pop with FIFO at 2 entries -> occupancy stays 2, no data loss, order preserved.
REQ-035 Assert rst_n low during WAIT -> all outputs to reset values immediately; div_done held low after release -> no issue until div_done high.
REQ-036 Divider model asserting done 1 edge vs 40 edges after calc -> ARM masks stale done; capture only on genuine completion.
